// File: rtl/mau_pkg.sv
// Shared types for the memory access unit: FSM states, access-size encodings, latched control.
package mau_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } mau_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       sgn;
  } mau_ctrl_t;

  // Access is illegal when the low address bits do not fit the size, or the size is reserved
  function automatic logic mau_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_HALF: return lane[0];
      SZ_WORD: return |lane;
      SZ_RSVD: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Little-endian lane extraction (loads, with optional sign extension) and lane merge (sub-word stores).
module mau_lane_align
  import mau_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] word,
  input  logic [1:0]       size,
  input  logic             sgn,
  input  logic [1:0]       lane,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] load_data_c,
  output logic [WIDTH-1:0] merge_data_c
);

  logic [4:0]       byte_sh;
  logic [4:0]       half_sh;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [WIDTH-1:0] byte_mask;
  logic [WIDTH-1:0] half_mask;

  always_comb begin
    byte_sh      = {lane, 3'b000};
    half_sh      = {lane[1], 4'b0000};
    byte_v       = 8'(word >> byte_sh);
    half_v       = 16'(word >> half_sh);
    byte_mask    = WIDTH'(8'hFF) << byte_sh;
    half_mask    = WIDTH'(16'hFFFF) << half_sh;
    load_data_c  = word;
    merge_data_c = wdata;
    case (size)
      SZ_BYTE: begin
        load_data_c  = {{(WIDTH-8){sgn & byte_v[7]}}, byte_v};
        merge_data_c = (word & ~byte_mask) | (WIDTH'(wdata[7:0]) << byte_sh);
      end
      SZ_HALF: begin
        load_data_c  = {{(WIDTH-16){sgn & half_v[15]}}, half_v};
        merge_data_c = (word & ~half_mask) | (WIDTH'(wdata[15:0]) << half_sh);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between a request/response port and a word-addressed data memory.
// Optional macro MAU_MISALIGN_CHECK_EN rejects misaligned or reserved-size requests.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_rdata,
  output logic              rsp_err,
  output logic [31:0]       mem_A,
  output logic              mem_WE,
  output logic [WIDTH-1:0]  mem_WriteData,
  input  logic [WIDTH-1:0]  mem_ReadData
);

  mau_state_e        state_q, state_d;
  mau_ctrl_t         ctrl_q, req_ctrl_c;
  logic [ADDR_W-1:0] addr_q;
  logic [WIDTH-1:0]  wdata_q;
  logic [WIDTH-1:0]  wr_word_q;
  logic              we_q;
  logic              req_err_c;
  logic              accept_c;
  logic              capture_c;
  logic [WIDTH-1:0]  load_c;
  logic [WIDTH-1:0]  merge_c;

  // Request decode: effective size and rejection
  always_comb begin
    req_ctrl_c.we  = req_we;
    req_ctrl_c.sgn = req_signed;
`ifdef MAU_MISALIGN_CHECK_EN
    req_ctrl_c.size = req_size;
    req_err_c       = mau_misaligned(req_size, req_addr[1:0]);
`else
    req_ctrl_c.size = (req_size == SZ_RSVD) ? SZ_WORD : req_size;
    req_err_c       = 1'b0;
`endif
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    accept_c  = 1'b0;
    capture_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept_c = 1'b1;
          if (req_err_c)                                  state_d = ST_RESP;
          else if (!req_we || req_ctrl_c.size != SZ_WORD) state_d = ST_RD;
          else                                            state_d = ST_WR;
        end
      end
      ST_RD: begin
        capture_c = 1'b1;
        state_d   = ctrl_q.we ? ST_WR : ST_RESP;
      end
      ST_WR:   state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Latched request, merged write word and response registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_word_q <= '0;
      we_q      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      we_q      <= (state_d == ST_WR);
      rsp_valid <= (state_d == ST_RESP);
      if (accept_c) begin
        ctrl_q    <= req_ctrl_c;
        addr_q    <= req_addr;
        wdata_q   <= req_wdata;
        wr_word_q <= req_wdata;
        rsp_err   <= req_err_c;
        rsp_rdata <= '0;
      end
      if (capture_c) begin
        if (ctrl_q.we) wr_word_q <= merge_c;
        else           rsp_rdata <= load_c;
      end
    end
  end

  mau_lane_align #(.WIDTH(WIDTH)) u_lane_align (
    .word         (mem_ReadData),
    .size         (ctrl_q.size),
    .sgn          (ctrl_q.sgn),
    .lane         (addr_q[1:0]),
    .wdata        (wdata_q),
    .load_data_c  (load_c),
    .merge_data_c (merge_c)
  );

  // Reset gates the handshake and the write strobe immediately, not just at the next edge
  assign req_ready     = rst & (state_q == ST_IDLE);
  assign mem_WE        = rst & we_q;
  assign mem_A         = 32'(addr_q >> 2);
  assign mem_WriteData = wr_word_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against an arithmetic memory/transaction model.
module tb_mem_access_unit;
  import mau_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_A;
  logic        mem_WE;
  logic [31:0] mem_WriteData;
  logic [31:0] mem_ReadData;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int we_cnt   = 0;
  int we_cyc   = 0;
  logic [31:0] last_rdata;

  mem_access_unit #(.WIDTH(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_A(mem_A), .mem_WE(mem_WE), .mem_WriteData(mem_WriteData), .mem_ReadData(mem_ReadData)
  );

  always #5 clk = ~clk;

  assign mem_ReadData = mem[mem_A[7:0]];
  always @(posedge clk) if (mem_WE === 1'b1) mem[mem_A[7:0]] = mem_WriteData;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (mem_WE === 1'b1) begin we_cnt++; we_cyc = cyc; end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: what a request does to memory and what it returns
  task automatic ref_txn(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [9:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err,
                         output int lat, output int wes);
    int unsigned sz, lane, sh, idx;
    logic [31:0] word, v, mask;
    sz   = size;
    lane = addr % 4;
    idx  = addr / 4;
    word = ref_mem[idx];
    err  = 1'b0;
`ifdef MAU_MISALIGN_CHECK_EN
    err = (sz == 1 && lane % 2 != 0) || (sz == 2 && lane != 0) || (sz == 3);
`else
    if (sz == 3) sz = 2;
`endif
    rdata = 32'h0;
    if (err) begin
      lat = 1; wes = 0;
    end else if (!we) begin
      lat = 2; wes = 0;
      if (sz == 0) begin
        sh = 8 * lane; v = (word >> sh) % 256;
        if (sgn && v >= 128) v = v - 256;
      end else if (sz == 1) begin
        sh = 16 * (lane / 2); v = (word >> sh) % 65536;
        if (sgn && v >= 32768) v = v - 65536;
      end else v = word;
      rdata = v;
    end else begin
      wes = 1;
      if (sz == 0) begin
        lat = 3; sh = 8 * lane; mask = 32'hFF << sh;
        ref_mem[idx] = (word & ~mask) | ((wdata % 256) << sh);
      end else if (sz == 1) begin
        lat = 3; sh = 16 * (lane / 2); mask = 32'hFFFF << sh;
        ref_mem[idx] = (word & ~mask) | ((wdata % 65536) << sh);
      end else begin
        lat = 2; ref_mem[idx] = wdata;
      end
    end
  endtask

  task automatic txn(input logic we, input logic [1:0] size, input logic sgn,
                     input logic [9:0] addr, input logic [31:0] wdata, input int hold);
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat, exp_we, lat, acc, wc0;
    bit          seen;
    ref_txn(we, size, sgn, addr, wdata, exp_rdata, exp_err, exp_lat, exp_we);
    wc0 = we_cnt;
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = 32'(addr); req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    acc = cyc; lat = 0; seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("mem_A", mem_A, 32'(addr >> 2));
      if (rsp_valid === 1'b1) seen = 1'b1;
    end
    if (!seen) check("rsp_timeout", 32'd0, 32'd1);
    else begin
      check("latency", 32'(lat), 32'(exp_lat));
      check("rsp_rdata", rsp_rdata, exp_rdata);
      check("rsp_err", 32'(rsp_err), 32'(exp_err));
      check("req_ready_resp", 32'(req_ready), 32'd0);
      last_rdata = rsp_rdata;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_rdata", rsp_rdata, exp_rdata);
      check("hold_err", 32'(rsp_err), 32'(exp_err));
      check("hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("we_pulses", 32'(we_cnt - wc0), 32'(exp_we));
    if (exp_we != 0) check("we_slot", 32'(we_cyc - acc), 32'(exp_lat - 2));
    check("mem_word", mem[addr[9:2]], ref_mem[addr[9:2]]);
    @(negedge clk);
    check("rsp_released", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] saved;
    int          wc0;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0; last_rdata = 32'h0;
    for (int i = 0; i < 256; i++) begin
      v = $urandom; mem[i] = v; ref_mem[i] = v;
    end

    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_mem_we", 32'(mem_WE), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);
    check("post_rst_err", 32'(rsp_err), 32'd0);
    check("post_rst_rdata", rsp_rdata, 32'd0);

    // Word store then load at 0x10
    txn(1'b1, SZ_WORD, 1'b0, 10'h010, 32'hDEADBEEF, 0);
    check("word_store_mem", mem[4], 32'hDEADBEEF);
    txn(1'b0, SZ_WORD, 1'b0, 10'h010, 32'h0, 0);
    check("word_load_data", last_rdata, 32'hDEADBEEF);

    // Byte merge into the top lane, then signed/unsigned byte loads
    txn(1'b1, SZ_WORD, 1'b0, 10'h010, 32'h11223344, 0);
    txn(1'b1, SZ_BYTE, 1'b0, 10'h013, 32'h000000A5, 0);
    check("byte_merge_mem", mem[4], 32'hA5223344);
    txn(1'b0, SZ_BYTE, 1'b1, 10'h013, 32'h0, 0);
    check("byte_load_signed", last_rdata, 32'hFFFFFFA5);
    txn(1'b0, SZ_BYTE, 1'b0, 10'h013, 32'h0, 0);
    check("byte_load_unsigned", last_rdata, 32'h000000A5);

    // Misaligned halfword load, reserved-size load, held response
    txn(1'b0, SZ_HALF, 1'b0, 10'h011, 32'h0, 0);
`ifndef MAU_MISALIGN_CHECK_EN
    check("half_lane0", last_rdata, 32'h00003344);
`endif
    txn(1'b0, SZ_RSVD, 1'b0, 10'h012, 32'h0, 0);
    txn(1'b0, SZ_WORD, 1'b0, 10'h010, 32'h0, 5);

    // Reset asserted while a sub-word store is in its write cycle
    saved = ref_mem[8];
    wc0 = we_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_BYTE; req_signed = 1'b0;
    req_addr = 32'h22; req_wdata = ~saved;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("wr_state_reached", 32'(mem_WE), 32'd1);
    rst = 1'b0; #1;
    check("rst_gates_we", 32'(mem_WE), 32'd0);
    @(posedge clk); #1;
    check("rst_no_write", mem[8], saved);
    @(negedge clk);
    check("rst_no_rsp", 32'(rsp_valid), 32'd0);
    check("rst_ready_low", 32'(req_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_back_idle", 32'(req_ready), 32'd1);
    check("rst_no_rsp2", 32'(rsp_valid), 32'd0);
    check("rst_we_count", 32'(we_cnt - wc0), 32'd0);

    // Random traffic over a small window so words get reused
    for (int t = 0; t < 150; t++) begin
      txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          10'($urandom_range(0, 127)), $urandom, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width.
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  request offered.
REQ-006 SHALL have port req_ready  output  1  request accepted when high together with req_valid.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-009 SHALL have port req_signed  input  1  sign-extend sub-word loads.
REQ-010 SHALL have port req_addr  input  ADDR_W  byte address.
REQ-011 SHALL have port req_wdata  input  WIDTH  store data, right-justified.
REQ-012 SHALL have port rsp_valid  output  1  response present; held until rsp_ready.
REQ-013 SHALL have port rsp_ready  input  1  response consumed.
REQ-014 SHALL have port rsp_rdata  output  WIDTH  load result, extended; 0 for stores.
REQ-015 SHALL have port rsp_err  output  1  request rejected (misaligned or reserved size).
REQ-016 SHALL have port mem_A  output  32  word index to data memory = req_addr >> 2.
REQ-017 SHALL have port mem_WE  output  1  word write enable; memory writes on posedge.
REQ-018 SHALL have port mem_WriteData  output  WIDTH  full word to write.
REQ-019 SHALL have port mem_ReadData  input  WIDTH  combinational read of word at mem_A.

Function
REQ-020 SHALL implement FSM IDLE, RD, WR, RESP; req_ready = 1 only in IDLE.
REQ-021 SHALL, on acceptance in IDLE, latch we/size/signed/addr/wdata; go RD for loads and sub-word stores, WR for word stores, RESP for errors.
REQ-022 SHALL in RD drive mem_A, capture mem_ReadData at posedge; load -> RESP, sub-word store -> WR.
REQ-023 SHALL in WR drive mem_WE = 1 for exactly one cycle with mem_WriteData = merged word, then -> RESP.
REQ-024 SHALL use little-endian lanes: byte lane = addr[1:0], halfword lane = addr[1].
REQ-025 SHALL merge sub-word stores by replacing only the addressed lane of the RD-captured word with req_wdata low bits.
REQ-026 SHALL extract loads from the addressed lane, zero-extended when req_signed = 0, sign-extended otherwise.
REQ-027 SHALL yield latency (acceptance edge to rsp_valid) of 2 cycles for load and word store, 3 for sub-word store, 1 for error.
REQ-028 SHALL in RESP hold rsp_valid/rsp_rdata/rsp_err stable until rsp_valid & rsp_ready, then -> IDLE; no new request accepted in the same cycle.
REQ-029 SHALL keep mem_WE = 0 in every state except WR; mem_A holds latched address outside IDLE.

Reset
REQ-030 SHALL, at a posedge with rst = 0, enter IDLE; rsp_valid, rsp_err, rsp_rdata, latched registers = 0.
REQ-031 SHALL gate mem_WE with rst so no memory write occurs while rst = 0, including reset asserted in WR.
REQ-032 SHALL drive req_ready = 0 while rst = 0; in-flight request discarded with no response.

Configuration
REQ-033 SHALL honour macro MAU_MISALIGN_CHECK_EN.
REQ-034 SHALL with macro defined: halfword with addr[0]=1, word with addr[1:0]!=0, or size 11 -> rsp_err = 1, no memory access.
REQ-035 SHALL without macro: ignore low address bits below access size, treat size 11 as word, tie rsp_err to 0.

Structure
REQ-036 SHALL place state enum and size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) in shared package mau_pkg.
REQ-037 SHALL put lane extract/merge logic in one combinational sub-module mau_lane_align.

Verification
REQ-038 SHALL cover word store addr 0x10 data 0xDEADBEEF then word load addr 0x10 -> mem_A = 4, one WE pulse, rdata 0xDEADBEEF, latencies 2/2.
REQ-039 SHALL cover byte store 0xA5 to addr 0x13 over word 0x11223344 -> memory word 0xA5223344, WE asserted in cycle 3 only, latency 3.
REQ-040 SHALL cover byte load addr 0x13 of 0xA5223344 signed -> 0xFFFFFFA5; unsigned -> 0x000000A5.
REQ-041 SHALL cover halfword load addr 0x11 with macro -> rsp_err = 1, latency 1, mem_WE never high; without macro -> lane 0 data.
REQ-042 SHALL cover rsp_ready held low 5 cycles -> rsp outputs stable, req_ready = 0 throughout.
REQ-043 SHALL cover rst = 0 during WR of sub-word store -> no write, memory unchanged, IDLE next cycle, no rsp_valid.
